// File: rtl/param_deser_pkg.sv
// Shared types and constants for the param_deser serial receiver.
//   deser_state_t : receiver FSM states (PAR only used when
//                   PARAM_DESER_PARITY_EN is defined)
//   START_BIT / STOP_BIT / IDLE_LEVEL : serial line levels
//   cnt_width()   : data-bit counter width for a W-bit word
package param_deser_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2,
      STOP = 2'd3
   } deser_state_t;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   // Counter must be able to hold the value W (one past the last bit index).
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/param_deser_shreg.sv
// W-bit right-shift register used to assemble an LSB-first serial word.
//   clk   : clock
//   rst   : synchronous active-high reset (clears word and parity)
//   clr   : synchronous clear at the start of each frame
//   shift : shift din in at the MSB end
//   din   : serial bit
//   q     : assembled word (first bit shifted in ends up at q[0])
//   par   : XOR of all bits shifted in since the last clear
module param_deser_shreg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         shift,
   input  logic         din,
   output logic [W-1:0] q,
   output logic         par
);

   logic [W-1:0] q_nxt;

   // A one-bit register has no upper slice to carry over.
   generate
      if (W == 1) begin : g_w1
         always_comb q_nxt = din;
      end else begin : g_wn
         always_comb q_nxt = {din, q[W-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q   <= '0;
         par <= 1'b0;
      end else if (shift) begin
         q   <= q_nxt;
         par <= par ^ din;
      end
   end

endmodule

// File: rtl/param_deser.sv
// Serial-to-parallel receiver: start bit (0), W = F-K+1 data bits LSB
// first, [even parity bit], stop bit (1). One bit is taken per en strobe.
// Optional parity checking is enabled by defining PARAM_DESER_PARITY_EN.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   d         : serial data, idles at 1
//   en        : bit strobe; d sampled only when en=1
//   q         : last good word, bit K = first data bit received
//   q_valid   : one-cycle pulse when q updates
//   frame_err : one-cycle pulse on bad stop bit (or bad parity)
//   busy      : high while a frame is in progress
module param_deser #(
   parameter int F = 10,
   parameter int K = (F > 2) ? 3 : 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       d,
   input  logic       en,
   output logic [F:K] q,
   output logic       q_valid,
   output logic       frame_err,
   output logic       busy
);

   import param_deser_pkg::*;

   localparam int unsigned W  = F - K + 1;
   localparam int unsigned CW = cnt_width(W);

   deser_state_t  state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          shift, clr, load, err_set;
   logic [W-1:0]  sr;
   logic          sr_par;
`ifdef PARAM_DESER_PARITY_EN
   logic          par_bad, par_bad_nxt;
   logic          stop_ok;
   assign stop_ok = (d == STOP_BIT) && !par_bad;
`else
   logic          stop_ok;
   assign stop_ok = (d == STOP_BIT);
`endif

   param_deser_shreg #(.W(W)) u_shreg (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .shift (shift),
      .din   (d),
      .q     (sr),
      .par   (sr_par)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      shift     = 1'b0;
      clr       = 1'b0;
      load      = 1'b0;
      err_set   = 1'b0;
`ifdef PARAM_DESER_PARITY_EN
      par_bad_nxt = par_bad;
`endif
      if (en) begin
         case (state)
            IDLE: begin
               if (d == START_BIT) begin
                  state_nxt = DATA;
                  cnt_nxt   = '0;
                  clr       = 1'b1;
`ifdef PARAM_DESER_PARITY_EN
                  par_bad_nxt = 1'b0;
`endif
               end
            end
            DATA: begin
               shift   = 1'b1;
               cnt_nxt = cnt + 1'b1;
               if (cnt == CW'(W - 1)) begin
`ifdef PARAM_DESER_PARITY_EN
                  state_nxt = PAR;
`else
                  state_nxt = STOP;
`endif
               end
            end
`ifdef PARAM_DESER_PARITY_EN
            PAR: begin
               // Even parity: the parity bit equals the XOR of the data bits.
               par_bad_nxt = (d != sr_par);
               state_nxt   = STOP;
            end
`endif
            STOP: begin
               // A low stop bit is consumed here; it never starts a new frame.
               state_nxt = IDLE;
               if (stop_ok) load    = 1'b1;
               else         err_set = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         q         <= '0;
         q_valid   <= 1'b0;
         frame_err <= 1'b0;
`ifdef PARAM_DESER_PARITY_EN
         par_bad   <= 1'b0;
`endif
      end else begin
         cnt       <= cnt_nxt;
         q_valid   <= load;
         frame_err <= err_set;
         if (load) q <= sr;
`ifdef PARAM_DESER_PARITY_EN
         par_bad   <= par_bad_nxt;
`endif
      end
   end

`ifndef PARAM_DESER_PARITY_EN
   // Running parity exists in the shift register but is only consumed
   // when parity checking is built in.
   logic unused_par;
   assign unused_par = sr_par;
`endif

   always_comb busy = (state != IDLE);

endmodule

// File: tb/tb_param_deser.sv
// Self-checking bench for param_deser (defaults F=10, K=3, W=8) plus a
// small F=2 instance. Honors PARAM_DESER_PARITY_EN when defined.
module tb_param_deser;

   logic        clk = 1'b0;
   logic        rst, d, en;
   logic [10:3] q;
   logic        q_valid, frame_err, busy;
   logic        d2, en2;
   logic [2:1]  q2;
   logic        q2_valid, ferr2, busy2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int overlap = 0;
   int vtimes[$];

`ifdef PARAM_DESER_PARITY_EN
   localparam int FRAME = 11;
`else
   localparam int FRAME = 10;
`endif

   always #5 clk = ~clk;

   param_deser u_dut (
      .clk(clk), .rst(rst), .d(d), .en(en),
      .q(q), .q_valid(q_valid), .frame_err(frame_err), .busy(busy)
   );

   param_deser #(.F(2)) u_small (
      .clk(clk), .rst(rst), .d(d2), .en(en2),
      .q(q2), .q_valid(q2_valid), .frame_err(ferr2), .busy(busy2)
   );

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (q_valid && frame_err) overlap++;
      if (q_valid) vtimes.push_back(cyc);
   end

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       par;
      logic       tog;
      logic       exp_v;
      logic       exp_e;
      logic [7:0] exp_q;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic tog);
      d  = b;
      en = 1'b1;
      tick();
      if (tog) begin
         en = 1'b0;
         d  = ~b;
         tick();
      end
   endtask

   // Sends start, data, [parity]; checks the line is still quiet and busy,
   // then drives the stop bit. Outputs are sampled right after that edge.
   task automatic send_frame(input logic [7:0] data, input logic stop,
                             input logic par, input logic tog);
      send_bit(1'b0, tog);
      for (int i = 0; i < 8; i++) send_bit(data[i], tog);
`ifdef PARAM_DESER_PARITY_EN
      send_bit(par, tog);
`else
      if (par) begin end
`endif
      check("pre_stop_valid", {31'd0, q_valid}, 32'd0);
      check("pre_stop_busy", {31'd0, busy}, 32'd1);
      d  = stop;
      en = 1'b1;
      tick();
   endtask

   initial begin
      int n;
      rst = 1'b1; d = 1'b1; en = 1'b0; d2 = 1'b1; en2 = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      check("rst_q", {24'd0, q}, 32'd0);
      check("rst_valid", {31'd0, q_valid}, 32'd0);
      check("rst_err", {31'd0, frame_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_q2", {30'd0, q2}, 32'd0);

      d = 1'b1; en = 1'b1;
      tick();

      vecs.push_back('{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5});
      vecs.push_back('{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5});
      vecs.push_back('{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C});
      vecs.push_back('{8'h81, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h81});
`ifdef PARAM_DESER_PARITY_EN
      vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81});
      vecs.push_back('{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h07});
`endif

      foreach (vecs[i]) begin
         send_frame(vecs[i].data, vecs[i].stop, vecs[i].par, vecs[i].tog);
         check($sformatf("v%0d_valid", i), {31'd0, q_valid}, {31'd0, vecs[i].exp_v});
         check($sformatf("v%0d_err", i), {31'd0, frame_err}, {31'd0, vecs[i].exp_e});
         check($sformatf("v%0d_q", i), {24'd0, q}, {24'd0, vecs[i].exp_q});
         check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
         d = 1'b1; en = 1'b1;
         tick();
         check($sformatf("v%0d_valid_1cyc", i), {31'd0, q_valid}, 32'd0);
         check($sformatf("v%0d_err_1cyc", i), {31'd0, frame_err}, 32'd0);
      end

      // Reset after the 4th data bit of 8'hFF abandons the frame silently.
      n = vtimes.size();
      send_bit(1'b0, 1'b0);
      repeat (4) send_bit(1'b1, 1'b0);
      rst = 1'b1; d = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_q", {24'd0, q}, 32'd0);
      check("midrst_valid", {31'd0, q_valid}, 32'd0);
      check("midrst_err", {31'd0, frame_err}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      repeat (6) send_bit(1'b1, 1'b0);
      check("midrst_idle_busy", {31'd0, busy}, 32'd0);
      send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
      check("after_rst_valid", {31'd0, q_valid}, 32'd1);
      check("after_rst_q", {24'd0, q}, 32'h0F);
      d = 1'b1; en = 1'b1;
      tick();
      check("after_rst_pulses", vtimes.size(), n + 1);

      // Back-to-back frames with no idle gap.
      vtimes.delete();
      send_frame(8'h01, 1'b1, 1'b1, 1'b0);
      check("b2b_q0", {24'd0, q}, 32'h01);
      send_frame(8'h80, 1'b1, 1'b1, 1'b0);
      check("b2b_q1", {24'd0, q}, 32'h80);
      d = 1'b1; en = 1'b1;
      tick();
      check("b2b_count", vtimes.size(), 32'd2);
      if (vtimes.size() == 2)
         check("b2b_spacing", vtimes[1] - vtimes[0], FRAME);

      // F=2, K=1 instance: frame 2'b10 sent LSB first.
      en2 = 1'b1;
      d2 = 1'b0; tick();
      d2 = 1'b0; tick();
      d2 = 1'b1; tick();
`ifdef PARAM_DESER_PARITY_EN
      d2 = 1'b1; tick();
`endif
      check("small_busy", {31'd0, busy2}, 32'd1);
      d2 = 1'b1; tick();
      check("small_valid", {31'd0, q2_valid}, 32'd1);
      check("small_err", {31'd0, ferr2}, 32'd0);
      check("small_q", {30'd0, q2}, 32'b10);
      tick();
      check("small_valid_1cyc", {31'd0, q2_valid}, 32'd0);

      check("no_overlap", overlap, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
